power_alu_seq: RTL

Parametrised, sequential successor to the 8-bit accumulator ALU. Executes a 4-bit-opcode instruction set on signed operand `a` and the registered accumulator `b`, which feeds back as the second operand. Adds a valid/ready handshake, a multi-cycle shift-add multiply, and registered status flags. Sits between the instruction sequencer and the datapath register file.

---
 rtl/power_alu_seq.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/power_alu_seq.sv
// power_alu_seq: accumulator ALU with valid/ready handshake and shift-add multiply.
// Define POWER_ALU_SAT_EN to clamp overflowing ADD/SUB/INC/DEC/MUL results instead of wrapping.
//
// state | meaning
// IDLE  | ready; single-cycle ops write b/flags on the accepting edge
// MUL   | shift-add multiply, one multiplier bit per edge, writes on the last
module power_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             res_valid,
  output logic             zf,
  output logic             nf,
  output logic             cf,
  output logic             vf
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
`ifdef POWER_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] OP_TRA  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_DEC  = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_XNOR = 4'hB;
  localparam logic [3:0] OP_GT   = 4'hC;
  localparam logic [3:0] OP_LT   = 4'hD;
  localparam logic [3:0] OP_EQ   = 4'hE;
  localparam logic [3:0] OP_NOT  = 4'hF;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, mcand_q;
  logic [WIDTH-1:0] mplr_q;
  logic             neg_q;

  logic             accept, mul_start, wr_en;
  logic [WIDTH-1:0] addend, mag_a, mag_b;
  logic             is_sub, is_arith, gt, lt;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] r_alu, r_mul, r_new;
  logic             c_alu, v_alu, v_mul, c_new, v_new;
  logic [PW-1:0]    acc_step, prod;

  assign op_ready = (state_q == IDLE) && !rst;
  assign accept   = op_valid && op_ready;

  // One shared adder/subtractor serves ADD/SUB/INC/DEC.
  always_comb begin
    addend   = b;
    is_sub   = 1'b0;
    is_arith = 1'b0;
    case (opcode)
      OP_INC:  begin addend = ONE; is_arith = 1'b1; end
      OP_ADD:  is_arith = 1'b1;
      OP_SUB:  begin is_sub = 1'b1; is_arith = 1'b1; end
      OP_DEC:  begin addend = ONE; is_sub = 1'b1; is_arith = 1'b1; end
      default: begin end
    endcase
    ext   = is_sub ? ({1'b0, a} - {1'b0, addend}) : ({1'b0, a} + {1'b0, addend});
    v_alu = is_arith && (ext[WIDTH-1] != a[WIDTH-1]) &&
            (is_sub ? (a[WIDTH-1] != addend[WIDTH-1]) : (a[WIDTH-1] == addend[WIDTH-1]));
    c_alu = is_arith && ext[WIDTH];
    gt    = $signed(a) > $signed(b);
    lt    = $signed(a) < $signed(b);

    r_alu = a;
    case (opcode)
      OP_TRA:  r_alu = a;
      OP_INC, OP_ADD, OP_SUB, OP_DEC:
               r_alu = (SAT && v_alu) ? (a[WIDTH-1] ? MIN_NEG : MAX_POS) : ext[WIDTH-1:0];
      OP_AND:  r_alu = a & b;
      OP_NAND: r_alu = ~(a & b);
      OP_OR:   r_alu = a | b;
      OP_NOR:  r_alu = ~(a | b);
      OP_XOR:  r_alu = a ^ b;
      OP_XNOR: r_alu = ~(a ^ b);
      OP_GT:   r_alu = {{(WIDTH-1){1'b0}}, gt};
      OP_LT:   r_alu = {{(WIDTH-1){1'b0}}, lt};
      OP_EQ:   r_alu = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_NOT:  r_alu = ~a;
      default: r_alu = a;
    endcase
  end

  // The final edge adds the last partial product and sign-corrects combinationally.
  always_comb begin
    mag_a    = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    mag_b    = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
    prod     = neg_q ? (PW'(0) - acc_step) : acc_step;
    v_mul    = !((&prod[PW-1:WIDTH-1]) || !(|prod[PW-1:WIDTH-1]));
    r_mul    = (SAT && v_mul) ? (neg_q ? MIN_NEG : MAX_POS) : prod[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    wr_en     = 1'b0;
    r_new     = r_alu;
    c_new     = c_alu;
    v_new     = v_alu;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d   = MUL;
            cnt_d     = '0;
            mul_start = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + CW'(1);
        r_new = r_mul;
        c_new = 1'b0;
        v_new = v_mul;
        if (cnt_q == LAST) begin
          wr_en   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b         <= '0;
      zf        <= 1'b0;
      nf        <= 1'b0;
      cf        <= 1'b0;
      vf        <= 1'b0;
      res_valid <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplr_q    <= '0;
      neg_q     <= 1'b0;
    end else begin
      res_valid <= wr_en;
      if (wr_en) begin
        b  <= r_new;
        zf <= (r_new == '0);
        nf <= r_new[WIDTH-1];
        cf <= c_new;
        vf <= v_new;
      end
      if (mul_start) begin
        acc_q   <= '0;
        mcand_q <= PW'(mag_a);
        mplr_q  <= mag_b;
        neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      end else if (state_q == MUL) begin
        acc_q   <= acc_step;
        mcand_q <= {mcand_q[PW-2:0], 1'b0};
        mplr_q  <= {1'b0, mplr_q[WIDTH-1:1]};
      end
    end
  end

endmodule
